// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the parallel-port bridge.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Holds the port data width, the register-bank addresses of the four
// port registers, the TX FIFO entry layout and the RX per-port state encoding.
package io_bridge_pkg;

  localparam int DATA_W = 16;

  // Register-bank addresses of the port registers.
  localparam logic [4:0] PI0_ADDR = 5'd28;
  localparam logic [4:0] PI1_ADDR = 5'd29;
  localparam logic [4:0] PO0_ADDR = 5'd30;
  localparam logic [4:0] PO1_ADDR = 5'd31;

  // One queued output-port write: which port it targets and the value.
  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] data;
  } tx_entry_t;

  // Per-input-port holding state.
  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_HELD  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a push into an empty FIFO is visible at the head one cycle later.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_dat    write request and data
//   pop               read request (ignored while empty)
//   head_dat          current head entry (valid while !empty)
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
module io_sync_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt_q;
  logic          wr_en;
  logic          rd_en;

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // push when it is popped at the same time; the write lands in the slot the
  // head is leaving (wr_ptr == rd_ptr when full).
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// Peripheral end of the CPU parallel port: queues PO0/PO1 writes out over a
// valid/ready link and holds incoming data in PI0/PI1 until the CPU reads it.
// Latency: PO write -> tx_valid one cycle; RX accept -> pi/pi_fresh one cycle.
// Backpressure: TX writes to a full FIFO are dropped (tx_ovf sticky); RX stalls
//   per port via rx_ready until the held value is read.
//
// Optional feature macro: IO_LOOPBACK_EN adds a 'loopback' input that routes
// the TX FIFO head into the RX path and silences both external links.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   po_wr, po_sel, po_data             CPU write to PO0 (addr 30) / PO1 (addr 31)
//   tx_valid, tx_ready, tx_data, tx_port  outbound link (FIFO head)
//   tx_ovf                             sticky: a PO write was dropped
//   rx_valid, rx_ready, rx_data, rx_port  inbound link, port 0=PI0, 1=PI1
//   pi_rd, pi_rd_sel                   CPU read-consume strobe for PI0/PI1
//   pi0, pi1                           held values (bank r28/r29)
//   pi_fresh                           per-port unread flags
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_W   = io_bridge_pkg::DATA_W,
  parameter int TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef IO_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              po_wr,
  input  logic              po_sel,
  input  logic [DATA_W-1:0] po_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_port,
  output logic              tx_ovf,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_port,
  input  logic              pi_rd,
  input  logic              pi_rd_sel,
  output logic [DATA_W-1:0] pi0,
  output logic [DATA_W-1:0] pi1,
  output logic [1:0]        pi_fresh
);

  localparam int EW = $bits(tx_entry_t);

  // ---------------------------------------------------------------- TX path
  tx_entry_t                  push_ent;
  tx_entry_t                  head_ent;
  logic [EW-1:0]              head_raw;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(TX_DEPTH):0]  unused_tx_cnt;
  logic                       head_vld;
  logic                       tx_ovf_q;

  always_comb begin
    push_ent      = '0;
    push_ent.port = po_sel;
    push_ent.data = po_data;
  end

  io_sync_fifo #(
    .W     (EW),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (po_wr),
    .push_dat (push_ent),
    .pop      (fifo_pop),
    .head_dat (head_raw),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_tx_cnt)
  );

  assign head_ent = tx_entry_t'(head_raw);
  assign head_vld = !fifo_empty;
  assign tx_data  = head_ent.data;
  assign tx_port  = head_ent.port;
  assign tx_ovf   = tx_ovf_q;

  // A write is lost only when the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
    end else if (po_wr && fifo_full && !fifo_pop) begin
      tx_ovf_q <= 1'b1;
    end
  end

  // ------------------------------------------------ RX source / link select
  rx_state_t         state_q [2];
  rx_state_t         state_d [2];
  logic [DATA_W-1:0] pi_q    [2];
  logic              src_vld;
  logic              src_port;
  logic [DATA_W-1:0] src_dat;
  logic [1:0]        accept;
  logic [1:0]        consume;

  always_comb begin
    src_vld  = rx_valid;
    src_port = rx_port;
    src_dat  = rx_data;
    tx_valid = head_vld;
    rx_ready = (state_q[rx_port] == RX_EMPTY);
    fifo_pop = head_vld && tx_ready;
`ifdef IO_LOOPBACK_EN
    // Loopback: the FIFO head is the RX source, popped only once its target
    // port can take it, so toggling loopback never drops a queued entry.
    if (loopback) begin
      src_vld  = head_vld;
      src_port = head_ent.port;
      src_dat  = head_ent.data;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      fifo_pop = head_vld && (state_q[head_ent.port] == RX_EMPTY);
    end
`endif
  end

  // ------------------------------------------------------- RX port FSMs
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      accept[i]  = 1'b0;
      consume[i] = 1'b0;
      case (state_q[i])
        RX_EMPTY: begin
          if (src_vld && (src_port == 1'(i))) begin
            accept[i]  = 1'b1;
            state_d[i] = RX_HELD;
          end
        end
        RX_HELD: begin
          // Read of an already-empty port falls in the other arm: no effect.
          if (pi_rd && (pi_rd_sel == 1'(i))) begin
            consume[i] = 1'b1;
            state_d[i] = RX_EMPTY;
          end
        end
        default: state_d[i] = RX_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= RX_EMPTY;
      state_q[1] <= RX_EMPTY;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  // Held value survives the read; only the fresh flag clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      pi_q[0] <= '0;
      pi_q[1] <= '0;
    end else begin
      if (accept[0]) pi_q[0] <= src_dat;
      if (accept[1]) pi_q[1] <= src_dat;
    end
  end

  assign pi0      = pi_q[0];
  assign pi1      = pi_q[1];
  assign pi_fresh = {state_q[1] == RX_HELD, state_q[0] == RX_HELD};

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: TX words are scoreboarded against
// a queue filled when the CPU write is driven and drained on each handshake.
// RX and flag behaviour are checked directly.
module tb_io_port_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        loopback;
  logic        po_wr;
  logic        po_sel;
  logic [15:0] po_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_port;
  logic        tx_ovf;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic        rx_port;
  logic        pi_rd;
  logic        pi_rd_sel;
  logic [15:0] pi0;
  logic [15:0] pi1;
  logic [1:0]  pi_fresh;

  int vectors     = 0;
  int miscompares = 0;

  logic [16:0] expq[$];
  int          mcnt;
  bit          movf;

  always #5 clk = ~clk;

  io_port_bridge #(.DATA_W(16), .TX_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef IO_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .po_wr     (po_wr),
    .po_sel    (po_sel),
    .po_data   (po_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_port   (tx_port),
    .tx_ovf    (tx_ovf),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_port   (rx_port),
    .pi_rd     (pi_rd),
    .pi_rd_sel (pi_rd_sel),
    .pi0       (pi0),
    .pi1       (pi1),
    .pi_fresh  (pi_fresh)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; the transfer completes at the next edge.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (expq.size() == 0) begin
        chk("tx_unexpected", {15'd0, tx_port, tx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = expq.pop_front();
        chk("tx_word", {15'd0, tx_port, tx_data}, {15'd0, e});
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    loopback  = 1'b0;
    po_wr     = 1'b0;
    po_sel    = 1'b0;
    po_data   = '0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    rx_port   = 1'b0;
    pi_rd     = 1'b0;
    pi_rd_sel = 1'b0;
    expq.delete();
    mcnt = 0;
    movf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One TX cycle: drive, advance the reference FIFO model, clock.
  task automatic step(input bit wr, input bit sel, input logic [15:0] d, input bit rdy);
    bit pop;
    bit push;
    po_wr    = wr;
    po_sel   = sel;
    po_data  = d;
    tx_ready = rdy;
    pop  = rdy && (mcnt > 0);
    push = 1'b0;
    if (wr) begin
      if (mcnt < 4 || pop) begin
        push = 1'b1;
        expq.push_back({sel, d});
      end else begin
        movf = 1'b1;
      end
    end
    mcnt = mcnt + int'(push) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_ovf",   tx_ovf,   0);
    chk("rst_tx_data",  tx_data,  0);
    chk("rst_pi0",      pi0,      0);
    chk("rst_pi1",      pi1,      0);
    chk("rst_fresh",    pi_fresh, 0);

    // First word, held under backpressure.
    step(1, 0, 16'hA5A5, 0);
    chk("fwft_valid", tx_valid, 1);
    chk("fwft_data",  tx_data,  16'hA5A5);
    chk("fwft_port",  tx_port,  0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("hold_data",  tx_data,  16'hA5A5);
    chk("hold_valid", tx_valid, 1);
    step(0, 0, 0, 1);
    chk("drain1_valid", tx_valid, 0);

    // Overflow: five writes into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) step(1, 1'(i), 16'(i), 0);
    chk("ovf_set", tx_ovf, 32'(movf));
    repeat (4) step(0, 0, 0, 1);
    chk("ovf_drain_valid", tx_valid, 0);
    chk("ovf_sb_empty", expq.size(), 0);
    chk("ovf_sticky", tx_ovf, 1);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1'(i), 16'h0010 + 16'(i), 0);
    step(1, 1, 16'h0055, 1);
    chk("fullpp_ovf",   tx_ovf,   0);
    chk("fullpp_valid", tx_valid, 1);
    repeat (4) step(0, 0, 0, 1);
    chk("fullpp_drained", tx_valid, 0);
    chk("fullpp_sb_empty", expq.size(), 0);
    // Pop attempts on empty must not disturb pointers.
    repeat (2) step(0, 0, 0, 1);
    chk("empty_rdy_valid", tx_valid, 0);
    step(1, 0, 16'h0077, 0);
    chk("after_empty_data", tx_data, 16'h0077);
    step(0, 0, 0, 1);
    chk("after_empty_drain", tx_valid, 0);
    tx_ready = 1'b0;

    // RX hold / stall / consume on port 1.
    rx_valid = 1'b1; rx_port = 1'b1; rx_data = 16'h1234;
    #1 chk("rx1_ready_empty", rx_ready, 1);
    cyc();
    chk("rx1_pi1",   pi1,      16'h1234);
    chk("rx1_fresh", pi_fresh, 2'b10);
    chk("rx1_ready_held", rx_ready, 0);
    rx_data = 16'h5678;
    cyc();
    cyc();
    chk("rx1_stall_pi1", pi1, 16'h1234);
    pi_rd = 1'b1; pi_rd_sel = 1'b1;
    cyc();
    pi_rd = 1'b0;
    chk("rd_retain_pi1", pi1,      16'h1234);
    chk("rd_clr_fresh",  pi_fresh, 2'b00);
    cyc();
    chk("rx1_second_pi1", pi1,      16'h5678);
    chk("rx1_second_frsh", pi_fresh, 2'b10);

    // Accept on port 0 while reading port 1.
    rx_port = 1'b0; rx_data = 16'h00FF;
    pi_rd = 1'b1; pi_rd_sel = 1'b1;
    cyc();
    rx_valid = 1'b0; pi_rd = 1'b0;
    chk("dual_pi0",   pi0,      16'h00FF);
    chk("dual_fresh", pi_fresh, 2'b01);
    chk("dual_pi1",   pi1,      16'h5678);

    // Read of an already-empty port.
    pi_rd = 1'b1; pi_rd_sel = 1'b1;
    cyc();
    pi_rd = 1'b0;
    chk("rd_empty_fresh", pi_fresh, 2'b01);

    // Reset discards queued TX words and held RX data.
    step(1, 1, 16'hCAFE, 0);
    do_reset();
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_fresh",    pi_fresh, 0);
    chk("midrst_pi0",      pi0,      0);

`ifdef IO_LOOPBACK_EN
    loopback = 1'b1;
    po_wr = 1'b1; po_sel = 1'b1; po_data = 16'hBEEF;
    cyc();
    po_wr = 1'b0;
    chk("lb_tx_valid_a", tx_valid, 0);
    chk("lb_rx_ready",   rx_ready, 0);
    cyc();
    chk("lb_pi1",        pi1,         16'hBEEF);
    chk("lb_fresh1",     pi_fresh[1], 1);
    chk("lb_tx_valid_b", tx_valid,    0);
    loopback = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
